// File: rtl/pe_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_skew_feeder_if
// Description : Handshake and skewed-output bundle between an operand source,
//               the skew feeder and one edge of the PE systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_skew_feeder_if #(
  parameter int LANES  = 4,
  parameter int MUL_BW = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [LANES*MUL_BW-1:0]   in_data;
  logic [1:0]                gemm_uno_i;
  logic [LANES*MUL_BW-1:0]   out_data;
  logic [LANES-1:0]          out_valid;
  logic [1:0]                gemm_uno_o;
  logic                      busy;
  logic                      done;

  // Operand source side
  modport master (
    output in_valid, in_last, in_data, gemm_uno_i,
    input  in_ready, out_data, out_valid, gemm_uno_o, busy, done
  );

  // Feeder side
  modport slave (
    input  in_valid, in_last, in_data, gemm_uno_i,
    output in_ready, out_data, out_valid, gemm_uno_o, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/pe_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pe_skew_feeder
// Description : Diagonal operand skewer for one edge of the PE array. Lane i
//               is delayed by i extra cycles; a stream end zero-flushes the
//               lines and pulses done. The PE mode is latched per stream.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_skew_feeder #(
  parameter int LANES  = 4,
  parameter int MUL_BW = 16
) (
  input  logic               clk,
  input  logic               rst,
  pe_skew_feeder_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic [LANES-1:0] last_sr;
  logic [1:0]       mode_q;

  // Reset blocks acceptance in the same cycle so no beat leaks past it.
  assign bus.in_ready   = !rst && (state != FLUSH);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = last_sr[LANES-1];
  assign bus.gemm_uno_o = mode_q;

  // One skew line per lane; depth grows with the lane index.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [MUL_BW-1:0] data_sr [0:i];
    logic [i:0]        vld_sr;
    logic [MUL_BW-1:0] inj_data;

    // Non-accepted cycles inject a zero bubble so idle lanes read as zero.
    assign inj_data = accept ? bus.in_data[i*MUL_BW +: MUL_BW] : '0;

    // Free-running shift: the array has no stall, so neither do the lines.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) begin
          data_sr[k] <= '0;
        end
        vld_sr <= '0;
      end else begin
        data_sr[0] <= inj_data;
        vld_sr[0]  <= accept;
        for (int k = 1; k <= i; k++) begin
          data_sr[k] <= data_sr[k-1];
          vld_sr[k]  <= vld_sr[k-1];
        end
      end
    end

    assign bus.out_valid[i]                  = vld_sr[i];
    assign bus.out_data[i*MUL_BW +: MUL_BW]  = vld_sr[i] ? data_sr[i] : '0;
  end : g_lane

  // Last-tag line tracks the final beat until it leaves the deepest lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_sr <= '0;
    end else begin
      last_sr[0] <= accept && bus.in_last;
      for (int k = 1; k < LANES; k++) begin
        last_sr[k] <= last_sr[k-1];
      end
    end
  end

  // Mode is captured only on the first beat so the PEs see it stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 2'b00;
    end else if ((state == IDLE) && accept) begin
      mode_q <= bus.gemm_uno_i;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: FLUSH ends in the cycle the last-tag reaches the end.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = bus.in_last ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (accept && bus.in_last) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (last_sr[LANES-1]) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire
